// File: rtl/udma_i2s_rx_arbiter.sv
// udma_i2s_rx_arbiter
// Merges two I2S RX sample channels into one uDMA RX stream. Each channel
// has its own FIFO. A single registered output stage is loaded from the
// granted FIFO, using either strict ch0/ch1 alternation or work-conserving
// round-robin.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   cfg_en_i[1:0]            per-channel enable
//   cfg_strict_i             1 = strict alternation, 0 = round-robin
//   cfg_clr_i                one-cycle datapath flush (overflow flags are kept)
//   chN_data_i, chN_valid_i  channel samples; sources have no backpressure
//   out_data_o, out_ch_o,
//   out_valid_o, out_ready_i merged output stage and its handshake
//   err_ovf_o[1:0]           sticky per-channel overflow flags
//   err_clr_i[1:0]           per-bit clear of err_ovf_o (a set wins over a clear)
module udma_i2s_rx_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            cfg_en_i,
  input  logic                  cfg_strict_i,
  input  logic                  cfg_clr_i,
  input  logic [DATA_WIDTH-1:0] ch0_data_i,
  input  logic [DATA_WIDTH-1:0] ch1_data_i,
  input  logic                  ch0_valid_i,
  input  logic                  ch1_valid_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_ch_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            err_ovf_o,
  input  logic [1:0]            err_clr_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [2][FIFO_DEPTH];
  logic [AW:0]           r_wr [2];
  logic [AW:0]           r_rd [2];
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_ch;
  logic                  r_out_valid;
  logic                  r_last;
  logic [1:0]            r_err;

  logic [DATA_WIDTH-1:0] w_din [2];
  logic [1:0]            w_empty;
  logic [1:0]            w_full;
  logic                  w_tgt;
  logic                  w_gnt_ch;
  logic                  w_gnt_vld;
  logic                  w_pop;
  logic [1:0]            w_pop_v;
  logic [1:0]            w_act;
  logic [1:0]            w_push;
  logic [1:0]            w_ovf_set;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_din[0] = ch0_data_i;
  assign w_din[1] = ch1_data_i;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      w_empty[n] = (r_wr[n] == r_rd[n]);
      // full: same slot index, opposite wrap bit
      w_full[n]  = (r_wr[n][AW-1:0] == r_rd[n][AW-1:0]) && (r_wr[n][AW] != r_rd[n][AW]);
    end
  end

  // Strict mode only waits on the target channel while that channel is
  // enabled; once it is disabled, arbitration falls back to round-robin.
  always_comb begin
    w_tgt     = ~r_last;
    w_gnt_ch  = 1'b0;
    w_gnt_vld = 1'b0;
    if (cfg_strict_i && cfg_en_i[w_tgt]) begin
      w_gnt_ch  = w_tgt;
      w_gnt_vld = ~w_empty[w_tgt];
    end else if (!w_empty[0] && !w_empty[1]) begin
      w_gnt_ch  = w_tgt;
      w_gnt_vld = 1'b1;
    end else if (!w_empty[0]) begin
      w_gnt_ch  = 1'b0;
      w_gnt_vld = 1'b1;
    end else if (!w_empty[1]) begin
      w_gnt_ch  = 1'b1;
      w_gnt_vld = 1'b1;
    end
  end

  assign w_pop     = w_gnt_vld & (~r_out_valid | out_ready_i) & ~cfg_clr_i;
  assign w_pop_v   = {w_pop & w_gnt_ch, w_pop & ~w_gnt_ch};
  assign w_act     = {ch1_valid_i, ch0_valid_i} & cfg_en_i & {2{~cfg_clr_i}};
  // A full FIFO still accepts a push if it is popped in the same cycle.
  assign w_push    = w_act & (~w_full | w_pop_v);
  assign w_ovf_set = w_act & w_full & ~w_pop_v;
  assign w_rd_data = r_mem[w_gnt_ch][r_rd[w_gnt_ch][AW-1:0]];

  always_ff @(posedge clk_i) begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (w_push[n]) r_mem[n][r_wr[n][AW-1:0]] <= w_din[n];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < 2; n++) begin
        r_wr[n] <= '0;
        r_rd[n] <= '0;
      end
      r_out_data  <= '0;
      r_out_ch    <= 1'b0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b1;
      r_err       <= '0;
    end else begin
      r_err <= (r_err & ~err_clr_i) | w_ovf_set;
      if (cfg_clr_i) begin
        for (int unsigned n = 0; n < 2; n++) begin
          r_wr[n] <= '0;
          r_rd[n] <= '0;
        end
        r_out_valid <= 1'b0;
        r_last      <= 1'b1;
      end else begin
        for (int unsigned n = 0; n < 2; n++) begin
          if (w_push[n])  r_wr[n] <= r_wr[n] + 1'b1;
          if (w_pop_v[n]) r_rd[n] <= r_rd[n] + 1'b1;
        end
        if (w_pop) begin
          r_out_data  <= w_rd_data;
          r_out_ch    <= w_gnt_ch;
          r_out_valid <= 1'b1;
          r_last      <= w_gnt_ch;
        end else if (out_ready_i) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_ch_o    = r_out_ch;
  assign out_valid_o = r_out_valid;
  assign err_ovf_o   = r_err;

endmodule

// File: tb/tb_udma_i2s_rx_arbiter.sv
// tb_udma_i2s_rx_arbiter
// Directed bench for udma_i2s_rx_arbiter (DATA_WIDTH=8, FIFO_DEPTH=4).
// Accepted output words are collected as {ch, data} and compared against
// hand-computed sequences.
module tb_udma_i2s_rx_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] cfg_en_i;
  logic       cfg_strict_i;
  logic       cfg_clr_i;
  logic [7:0] ch0_data_i;
  logic [7:0] ch1_data_i;
  logic       ch0_valid_i;
  logic       ch1_valid_i;
  logic [7:0] out_data_o;
  logic       out_ch_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [1:0] err_ovf_o;
  logic [1:0] err_clr_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [8:0]  q[$];

  udma_i2s_rx_arbiter #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_strict_i(cfg_strict_i),
    .cfg_clr_i(cfg_clr_i), .ch0_data_i(ch0_data_i), .ch1_data_i(ch1_data_i),
    .ch0_valid_i(ch0_valid_i), .ch1_valid_i(ch1_valid_i), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .err_ovf_o(err_ovf_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) q.push_back({out_ch_o, out_data_o});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] qget(input int i);
    return (q.size() > i) ? q[i] : 9'h1FF;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic idle_in();
    ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;
    cfg_clr_i   = 1'b0; err_clr_i   = 2'b00;
  endtask

  task automatic push(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    ch0_valid_i = v0; ch0_data_i = d0;
    ch1_valid_i = v1; ch1_data_i = d1;
    tick();
    ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;
  endtask

  task automatic flush();
    cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cfg_en_i = 2'b11; cfg_strict_i = 1'b0; out_ready_i = 1'b1;
    ch0_data_i = '0; ch1_data_i = '0;
    idle_in();
    tick(2);
    rst_i = 1'b0;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data",  32'(out_data_o),  32'd0);
    chk("rst_ch",    32'(out_ch_o),    32'd0);
    chk("rst_err",   32'(err_ovf_o),   32'd0);

    // Round-robin, simultaneous pushes on both channels
    push(1'b1, 8'hA0, 1'b1, 8'hB0);
    chk("lat_k", 32'(out_valid_o), 32'd0);
    push(1'b1, 8'hA1, 1'b1, 8'hB1);
    chk("lat_k1_valid", 32'(out_valid_o), 32'd1);
    chk("lat_k1_data",  32'(out_data_o),  32'hA0);
    tick(6);
    chk("rr_count", 32'(q.size()), 32'd4);
    chk("rr_0", 32'(qget(0)), 32'h0A0);
    chk("rr_1", 32'(qget(1)), 32'h1B0);
    chk("rr_2", 32'(qget(2)), 32'h0A1);
    chk("rr_3", 32'(qget(3)), 32'h1B1);
    q.delete();

    // Strict alternation: ch1 waits until ch0 has produced
    flush();
    cfg_strict_i = 1'b1;
    push(1'b0, 8'h00, 1'b1, 8'hB0);
    tick(4);
    chk("strict_wait_q",     32'(q.size()),    32'd0);
    chk("strict_wait_valid", 32'(out_valid_o), 32'd0);
    push(1'b1, 8'hA0, 1'b0, 8'h00);
    tick(4);
    chk("strict_count", 32'(q.size()), 32'd2);
    chk("strict_0", 32'(qget(0)), 32'h0A0);
    chk("strict_1", 32'(qget(1)), 32'h1B0);
    q.delete();
    cfg_strict_i = 1'b0;

    // Overflow on ch0 with out_ready_i low
    flush();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
    tick();
    chk("ovf_hold_valid", 32'(out_valid_o), 32'd1);
    chk("ovf_hold_data",  32'(out_data_o),  32'h10);
    chk("ovf_none_yet",   32'(err_ovf_o),   32'd0);
    push(1'b1, 8'h15, 1'b0, 8'h00);
    chk("ovf_set", 32'(err_ovf_o), 32'b01);
    err_clr_i = 2'b01;
    push(1'b1, 8'h16, 1'b0, 8'h00);
    chk("ovf_set_beats_clr", 32'(err_ovf_o), 32'b01);
    tick();
    err_clr_i = 2'b00;
    chk("ovf_cleared", 32'(err_ovf_o), 32'b00);
    out_ready_i = 1'b1;
    tick(8);
    chk("ovf_count", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("ovf_drain", 32'(qget(i)), 32'h010 + 32'(i));
    q.delete();

    // Output stage held stable under backpressure
    flush();
    out_ready_i = 1'b0;
    push(1'b0, 8'h00, 1'b1, 8'hC0);
    tick();
    for (int i = 0; i < 10; i++) begin
      push(1'b0, 8'h00, 1'b1, 8'hC1 + 8'(i));
      chk("hold_valid", 32'(out_valid_o), 32'd1);
      chk("hold_data",  32'(out_data_o),  32'hC0);
      chk("hold_ch",    32'(out_ch_o),    32'd1);
    end
    chk("hold_err", 32'(err_ovf_o), 32'b10);
    out_ready_i = 1'b1;
    tick(8);
    chk("hold_first", 32'(qget(0)), 32'h1C0);
    chk("hold_count", 32'(q.size()), 32'd5);
    q.delete();

    // Flush with simultaneous input; ch1 overflow flag from above must survive
    out_ready_i = 1'b0;
    push(1'b1, 8'hD0, 1'b1, 8'hE0);
    push(1'b1, 8'hD1, 1'b0, 8'h00);
    tick(2);
    chk("clr_pre_valid", 32'(out_valid_o), 32'd1);
    cfg_clr_i = 1'b1; ch0_valid_i = 1'b1; ch0_data_i = 8'hDF;
    tick();
    cfg_clr_i = 1'b0; ch0_valid_i = 1'b0;
    chk("clr_valid", 32'(out_valid_o), 32'd0);
    chk("clr_err",   32'(err_ovf_o),   32'b10);
    out_ready_i = 1'b1;
    tick(4);
    chk("clr_no_stale", 32'(q.size()), 32'd0);
    push(1'b1, 8'hD5, 1'b1, 8'hE5);
    tick(4);
    chk("clr_next_ch0", 32'(qget(0)), 32'h0D5);
    chk("clr_next_ch1", 32'(qget(1)), 32'h1E5);
    q.delete();
    err_clr_i = 2'b11;
    tick();
    err_clr_i = 2'b00;

    // Disabled channel is ignored; reset mid-stream
    cfg_en_i = 2'b01;
    push(1'b0, 8'h00, 1'b1, 8'hF0);
    tick(3);
    chk("dis_q",     32'(q.size()),    32'd0);
    chk("dis_err",   32'(err_ovf_o),   32'd0);
    chk("dis_valid", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b1, 8'h70 + 8'(i), 1'b0, 8'h00);
    chk("pre_rst_err",  32'(err_ovf_o),  32'b01);
    chk("pre_rst_data", 32'(out_data_o), 32'h70);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_data",  32'(out_data_o),  32'd0);
    chk("mid_rst_ch",    32'(out_ch_o),    32'd0);
    chk("mid_rst_err",   32'(err_ovf_o),   32'd0);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    tick(4);
    chk("rst_discard", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
